// File: rtl/tmds_pkg.sv
// Shared types and control-symbol constants for the TMDS channel encoder.
package tmds_pkg;

  typedef logic [9:0] tmds_sym_t;
  typedef logic [8:0] qm_t;

  localparam tmds_sym_t CTRL_00 = 10'b1101010100;
  localparam tmds_sym_t CTRL_01 = 10'b0010101011;
  localparam tmds_sym_t CTRL_10 = 10'b0101010100;
  localparam tmds_sym_t CTRL_11 = 10'b1010101011;

  function automatic tmds_sym_t ctrl_symbol(input logic [1:0] ctrl);
    tmds_sym_t sym;
    case (ctrl)
      2'b00:   sym = CTRL_00;
      2'b01:   sym = CTRL_01;
      2'b10:   sym = CTRL_10;
      default: sym = CTRL_11;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/tmds_channel_encoder_tm_choice.sv
// Transition-minimization stage: picks XOR or XNOR chaining to reduce
// transitions in the 8-bit word; bit 8 records the choice (1 = XOR).
module tm_choice
  import tmds_pkg::*;
(
  input  logic [7:0] i_data,
  output qm_t        o_qm
);

  logic [3:0] w_ones;
  logic       w_use_xnor;

  always_comb begin
    w_ones     = 4'($countones(i_data));
    w_use_xnor = (w_ones > 4'd4) || ((w_ones == 4'd4) && !i_data[0]);
    o_qm       = '0;
    o_qm[0]    = i_data[0];
    for (int i = 1; i < 8; i++) begin
      o_qm[i] = w_use_xnor ? ~(i_data[i] ^ o_qm[i-1]) : (i_data[i] ^ o_qm[i-1]);
    end
    o_qm[8] = ~w_use_xnor;
  end

endmodule

// File: rtl/tmds_channel_encoder.sv
// 8b/10b TMDS channel encoder: transition minimization, running DC balance and
// control-symbol insertion, two registered stages from input to o_tmds.
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7:0]              i_data,
  input  logic [1:0]              i_ctrl,
  input  logic                    i_ve,
  output logic [9:0]              o_tmds,
  output logic signed [CNT_W-1:0] o_disparity
);

  // Continuous stream: no valid/ready; every cycle consumes one input and
  // produces one symbol, with a fixed two-cycle delay.
  qm_t                     w_qm;
  qm_t                     r_qm;
  logic                    r_ve_s1;
  logic [1:0]              r_ctrl_s1;
  tmds_sym_t               r_tmds;
  logic signed [CNT_W-1:0] r_cnt;

  tm_choice u_tm_choice (
    .i_data (i_data),
    .o_qm   (w_qm)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_qm      <= '0;
      r_ve_s1   <= 1'b0;
      r_ctrl_s1 <= 2'b00;
    end else begin
      r_qm      <= w_qm;
      r_ve_s1   <= i_ve;
      r_ctrl_s1 <= i_ctrl;
    end
  end

  logic [3:0]              w_n1;
  logic [3:0]              w_n0;
  logic signed [CNT_W-1:0] w_diff;
  logic signed [CNT_W-1:0] w_two_qm8;
  logic signed [CNT_W-1:0] w_two_nqm8;
  logic                    w_cnt_pos;
  logic                    w_cnt_neg;
  tmds_sym_t               w_tmds_nxt;
  logic signed [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_n1       = 4'($countones(r_qm[7:0]));
    w_n0       = 4'd8 - w_n1;
    // Counts are 0..8, so widen with zeros before taking the signed difference.
    w_diff     = CNT_W'(w_n1) - CNT_W'(w_n0);
    w_two_qm8  = r_qm[8] ? CNT_W'(2) : '0;
    w_two_nqm8 = r_qm[8] ? '0 : CNT_W'(2);
    w_cnt_neg  = r_cnt[CNT_W-1];
    w_cnt_pos  = !r_cnt[CNT_W-1] && (r_cnt != '0);
    w_tmds_nxt = '0;
    w_cnt_nxt  = '0;
    if (!r_ve_s1) begin
      w_tmds_nxt = ctrl_symbol(r_ctrl_s1);
      w_cnt_nxt  = '0;
    end else if ((r_cnt == '0) || (w_n1 == w_n0)) begin
      w_tmds_nxt = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
      w_cnt_nxt  = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
    end else if ((w_cnt_pos && (w_n1 > w_n0)) || (w_cnt_neg && (w_n0 > w_n1))) begin
      w_tmds_nxt = {1'b1, r_qm[8], ~r_qm[7:0]};
      w_cnt_nxt  = r_cnt + w_two_qm8 - w_diff;
    end else begin
      w_tmds_nxt = {1'b0, r_qm[8], r_qm[7:0]};
      w_cnt_nxt  = r_cnt + w_diff - w_two_nqm8;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmds <= '0;
      r_cnt  <= '0;
    end else begin
      r_tmds <= w_tmds_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_tmds      = r_tmds;
  assign o_disparity = r_cnt;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Bench for tmds_channel_encoder: directed literal sequences plus a long
// random stream checked every cycle against a symbol-level reference model.
module tb_tmds_channel_encoder;

  logic              clk  = 1'b0;
  logic              rst  = 1'b1;
  logic              ve   = 1'b0;
  logic [1:0]        ctrl = 2'b00;
  logic [7:0]        data = 8'h00;
  logic [9:0]        tmds;
  logic signed [4:0] disp;

  int n_tests = 0;
  int n_fail  = 0;
  int m_disp  = 0;

  logic [9:0] exp_q[$];
  int         exp_disp_q[$];
  bit         exp_vid_q[$];
  logic [7:0] exp_byte_q[$];

  tmds_channel_encoder #(.CNT_W(5)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data      (data),
    .i_ctrl      (ctrl),
    .i_ve        (ve),
    .o_tmds      (tmds),
    .o_disparity (disp)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: the stage-1 registers clear to "control 00", so the
  // first symbol after reset is always that control symbol.
  task automatic model_reset();
    exp_q.delete(); exp_disp_q.delete(); exp_vid_q.delete(); exp_byte_q.delete();
    m_disp = 0;
    exp_q.push_back(10'b1101010100);
    exp_disp_q.push_back(0);
    exp_vid_q.push_back(1'b0);
    exp_byte_q.push_back(8'h00);
  endtask

  task automatic model_push(input bit v, input logic [1:0] c, input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] sym;
    int         ones, n1;
    bit         use_xnor, inv;
    if (!v) begin
      case (c)
        2'b00:   sym = 10'h354;
        2'b01:   sym = 10'h0AB;
        2'b10:   sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
      m_disp = 0;
    end else begin
      ones     = $countones(d);
      use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++)
        qm[i] = use_xnor ? ~(d[i] ^ qm[i-1]) : (d[i] ^ qm[i-1]);
      qm[8] = ~use_xnor;
      n1    = $countones(qm[7:0]);
      // Decide whether to invert the data bits; the disparity then simply
      // accumulates ones-minus-zeros of the emitted 10-bit symbol.
      if (m_disp == 0 || n1 == 4) inv = ~qm[8];
      else if ((m_disp > 0 && n1 > 4) || (m_disp < 0 && n1 < 4)) inv = 1'b1;
      else inv = 1'b0;
      sym    = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
      m_disp = m_disp + 2 * $countones(sym) - 10;
    end
    exp_q.push_back(sym);
    exp_disp_q.push_back(m_disp);
    exp_vid_q.push_back(v);
    exp_byte_q.push_back(d);
  endtask

  function automatic logic [7:0] decode(input logic [9:0] sym);
    logic [7:0] q, d;
    q    = sym[9] ? ~sym[7:0] : sym[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++)
      d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  // scoreboard: one compare per cycle, #1 after the rising edge
  logic       mon_rst;
  bit         mon_ve;
  logic [1:0] mon_ctrl;
  logic [7:0] mon_data;
  logic [9:0] mon_sym;
  int         mon_disp;
  bit         mon_vid;
  logic [7:0] mon_byte;

  always @(posedge clk) begin
    mon_rst  = rst;
    mon_ve   = ve;
    mon_ctrl = ctrl;
    mon_data = data;
    #1;
    if (mon_rst) begin
      model_reset();
      check("reset_tmds", int'(tmds), 0);
      check("reset_disp", int'(disp), 0);
    end else if (exp_q.size() == 0) begin
      check("model_queue_empty", 0, 1);
    end else begin
      mon_sym  = exp_q.pop_front();
      mon_disp = exp_disp_q.pop_front();
      mon_vid  = exp_vid_q.pop_front();
      mon_byte = exp_byte_q.pop_front();
      check("tmds", int'(tmds), int'(mon_sym));
      check("disparity", int'(disp), mon_disp);
      n_tests++;
      if (int'(disp) > 10 || int'(disp) < -10) begin
        n_fail++;
        $display("FAIL disparity_range: got %0d required within -10..10", disp);
      end
      if (mon_vid) check("decode", int'(decode(tmds)), int'(mon_byte));
      model_push(mon_ve, mon_ctrl, mon_data);
    end
  end

  // driver
  task automatic step(input bit v, input logic [1:0] c, input logic [7:0] d);
    @(negedge clk);
    ve   = v;
    ctrl = c;
    data = d;
  endtask

  task automatic lit(input string name, input logic [9:0] exp_sym, input int exp_disp);
    check({name, "_tmds"}, int'(tmds), int'(exp_sym));
    check({name, "_disp"}, int'(disp), exp_disp);
  endtask

  initial begin
    rst  = 1'b1;
    ve   = 1'b1;
    data = 8'hA5;
    repeat (4) begin
      @(negedge clk);
      lit("reset_hold", 10'h000, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    ve  = 1'b0;
    ctrl = 2'b00;
    step(0, 2'b00, 8'h00);
    step(0, 2'b00, 8'h00);

    // control symbols
    step(0, 2'b00, 8'h00);
    step(0, 2'b01, 8'h00);
    step(0, 2'b10, 8'h00); lit("ctrl00", 10'h354, 0);
    step(0, 2'b11, 8'h00); lit("ctrl01", 10'h0AB, 0);
    step(0, 2'b00, 8'h00); lit("ctrl10", 10'h154, 0);
    step(0, 2'b00, 8'h00); lit("ctrl11", 10'h2AB, 0);

    // disparity sequence for 0x00
    step(1, 2'b00, 8'h00);
    step(1, 2'b00, 8'h00);
    step(1, 2'b00, 8'h00); lit("zero_1", 10'h100, -8);
    step(0, 2'b00, 8'h00); lit("zero_2", 10'h3FF, 2);
    step(0, 2'b00, 8'h00); lit("zero_3", 10'h100, -6);
    step(0, 2'b00, 8'h00); lit("zero_blank", 10'h354, 0);

    // XNOR path
    step(1, 2'b00, 8'hFF);
    step(0, 2'b00, 8'h00);
    step(0, 2'b00, 8'h00); lit("xnor_ff", 10'h200, -8);

    // mid-stream blanking for a single cycle
    step(1, 2'b00, 8'h00);
    step(1, 2'b00, 8'h00);
    step(1, 2'b00, 8'h00); lit("mid_1", 10'h100, -8);
    step(0, 2'b00, 8'h00); lit("mid_2", 10'h3FF, 2);
    step(1, 2'b00, 8'h00); lit("mid_3", 10'h100, -6);
    step(1, 2'b00, 8'h00); lit("mid_blank", 10'h354, 0);
    step(0, 2'b00, 8'h00); lit("mid_restart", 10'h100, -8);

    // asynchronous reset between edges
    step(1, 2'b00, 8'h3C);
    step(1, 2'b00, 8'h3C);
    step(1, 2'b00, 8'h3C);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    lit("async_reset", 10'h000, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // random stream with random blanking
    repeat (10000) begin
      step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    repeat (3) step(0, 2'b00, 8'h00);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
